mcs_fpro_bridge_gen: RTL

Parametrised successor to the fixed two-region MCS-to-FPro bridge. It converts MicroBlaze MCS IO-bus transactions into single-cycle FPro bus strobes. It decodes N_CS chip-select regions, supports slaves with a configurable read latency, and forwards byte enables. It completes unmapped accesses safely so the CPU never hangs. It sits between the cpu IO bus and the mmio/video subsystems in the top level.

---
 rtl/mcs_fpro_bridge_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mcs_fpro_bridge_gen.sv
// MicroBlaze MCS IO-bus to FPro bus bridge: N_CS regions, RD_LAT-cycle read latency, byte enables.
// Define BRG_ERR_CNT_EN to build the saturating unmapped/illegal/busy access counter on err_cnt.
module mcs_fpro_bridge_gen #(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int unsigned N_CS     = 2,
    parameter int unsigned ADDR_W   = 21,
    parameter int unsigned RD_LAT   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_addr_strobe,
    input  logic                   io_read_strobe,
    input  logic                   io_write_strobe,
    input  logic [3:0]             io_byte_enable,
    input  logic [31:0]            io_address,
    input  logic [31:0]            io_write_data,
    output logic [31:0]            io_read_data,
    output logic                   io_ready,
    output logic [N_CS-1:0]        fp_cs,
    output logic                   fp_wr,
    output logic                   fp_rd,
    output logic [3:0]             fp_be,
    output logic [ADDR_W-1:0]      fp_addr,
    output logic [31:0]            fp_wr_data,
    input  logic [32*N_CS-1:0]     fp_rd_data,
    output logic [15:0]            err_cnt
);

    // Legal configurations satisfy ADDR_W + 2 + CS_W <= 24 so region and word address never overlap.
    localparam int unsigned CS_W      = (N_CS > 1) ? $clog2(N_CS) : 0;
    localparam int unsigned IDX_W     = (CS_W > 0) ? CS_W : 1;
    localparam logic [2:0]  WAIT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_rd;
    logic                r_hit;
    logic [IDX_W-1:0]    r_idx;
    logic [2:0]          r_wcnt;
    logic [31:0]         r_rdata;

    logic                w_start;
    logic                w_legal;
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_rd_slice;
    logic                w_unused_addr;

    assign w_start       = (r_state == S_IDLE) && io_addr_strobe;
    assign w_legal       = io_read_strobe ^ io_write_strobe;
    assign w_hit         = (io_address[31:24] == BRG_BASE[31:24]);
    assign w_unused_addr = ^io_address;

    generate
        if (CS_W == 0) begin : g_one_region
            assign w_idx = '0;
        end else begin : g_multi_region
            assign w_idx = io_address[23 -: CS_W];
        end
    endgenerate

    always_comb begin
        w_rd_slice = '0;
        for (int unsigned k = 0; k < N_CS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_rd_slice = fp_rd_data[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Misses and writes bypass WAIT even when RD_LAT is nonzero.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (io_addr_strobe) w_state_next = S_ACC;
            S_ACC:  w_state_next = (r_hit && r_rd && (RD_LAT != 0)) ? S_WAIT : S_DONE;
            S_WAIT: if (r_wcnt == 3'd0) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Illegal strobes are recorded as read-direction misses so they return zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rd    <= 1'b0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= io_address[ADDR_W+1:2];
                r_wdata <= io_write_data;
                r_be    <= io_byte_enable;
                r_rd    <= io_read_strobe | ~io_write_strobe;
                r_hit   <= w_hit & w_legal;
                r_idx   <= w_idx;
            end
            if (r_state == S_ACC) begin
                r_wcnt <= WAIT_INIT;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
            if ((r_state != S_DONE) && (w_state_next == S_DONE) && r_rd) begin
                r_rdata <= r_hit ? w_rd_slice : '0;
            end
        end
    end

    always_comb begin
        fp_cs        = '0;
        fp_wr        = 1'b0;
        fp_rd        = 1'b0;
        fp_be        = '0;
        fp_addr      = '0;
        fp_wr_data   = '0;
        io_ready     = (r_state == S_DONE);
        io_read_data = r_rdata;
        if ((r_state == S_ACC) && r_hit) begin
            for (int unsigned k = 0; k < N_CS; k++) begin
                fp_cs[k] = (r_idx == IDX_W'(k));
            end
            fp_wr = ~r_rd;
            fp_rd = r_rd;
        end
        if (r_state != S_IDLE) begin
            fp_addr    = r_addr;
            fp_be      = r_be;
            fp_wr_data = r_wdata;
        end
    end

`ifdef BRG_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_evt;

    assign w_err_evt = (w_start && !(w_hit && w_legal)) || ((r_state != S_IDLE) && io_addr_strobe);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule
